// File: rtl/ft245_sync_bridge.sv
// ---------------------------------------------------------------------------
// ft245_sync_bridge
//
// FPGA-side master for an FT245-style synchronous FIFO bus. Host-to-FPGA
// words on din are collected into a 4-entry receive FIFO that feeds a
// ready/valid stream. Words from a ready/valid transmit stream are collected
// in a 2-entry transmit FIFO and written out on dout.
//
// Ports
//   clk, rst_n           bus clock, asynchronous active-low reset
//   rxfn, txen           host flags (low = data to read / room to write)
//   din                  read data from the host
//   dout, oen, rdn, wrn  registered bus outputs (strobes active-low)
//   rx_data/rx_valid/rx_ready   receive stream toward the core
//   tx_data/tx_valid/tx_ready   transmit stream from the core
//
// Bus sequencing: IDLE -> RD_OE -> RD -> TURN -> IDLE for reads,
// IDLE -> WR -> TURN -> IDLE for writes. TURN is a single cycle with all
// strobes high, so the host and the FPGA never drive the data lines at the
// same time.
// ---------------------------------------------------------------------------
module ft245_sync_bridge #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxfn,
    input  logic              txen,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              oen,
    output logic              rdn,
    output logic              wrn,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_OE = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;

    // ------------------------------------------------------------------
    // State and bus output registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic              oen_q, oen_d;
    logic              rdn_q, rdn_d;
    logic              wrn_q, wrn_d;
    logic              last_rd_q, last_rd_d;   // 1: last burst served was a read
    logic [DATA_W-1:0] dout_q, dout_d;

    // ------------------------------------------------------------------
    // Receive FIFO (4 entries)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem_q [4];
    logic [1:0]        rx_wptr_q, rx_rptr_q;
    logic [2:0]        rx_cnt_q, rx_cnt_d;
    logic              rx_valid_q;
    logic              rx_push, rx_pop;

    // ------------------------------------------------------------------
    // Transmit FIFO (2 entries)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem_q [2];
    logic              tx_wptr_q, tx_rptr_q;
    logic [1:0]        tx_cnt_q, tx_cnt_d;
    logic              tx_ready_q;
    logic              tx_push, tx_load;

    logic              rd_req, wr_req;

    // A word is taken from the host at every edge where our read strobe is
    // low and the host still flags data.
    assign rx_push = ~rdn_q & ~rxfn;
    assign rx_pop  = rx_valid_q & rx_ready;

    always_comb begin
        rx_cnt_d = rx_cnt_q + {2'b00, rx_push} - {2'b00, rx_pop};
    end

    assign tx_push = tx_valid & tx_ready_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q + {1'b0, tx_push} - {1'b0, tx_load};
    end

    // Read needs three free receive entries (count <= 1); write needs a word.
    assign rd_req = ~rxfn & (rx_cnt_q <= 3'd1);
    assign wr_req = ~txen & (tx_cnt_q != 2'd0);

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        oen_d     = oen_q;
        rdn_d     = rdn_q;
        wrn_d     = wrn_q;
        last_rd_d = last_rd_q;
        tx_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // With both requests pending, serve the side not served last.
                if (rd_req && (!wr_req || !last_rd_q)) begin
                    state_d   = S_RD_OE;
                    oen_d     = 1'b0;
                    last_rd_d = 1'b1;
                end else if (wr_req) begin
                    state_d   = S_WR;
                    wrn_d     = 1'b0;
                    tx_load   = 1'b1;
                    last_rd_d = 1'b0;
                end
            end
            S_RD_OE: begin
                if (rxfn) begin
                    state_d = S_TURN;
                    oen_d   = 1'b1;
                end else begin
                    state_d = S_RD;
                    rdn_d   = 1'b0;
                end
            end
            S_RD: begin
                // Look at the post-edge fill level so the strobe is released
                // before the FIFO can run short of headroom.
                if (rxfn || (rx_cnt_d > 3'd1)) begin
                    state_d = S_TURN;
                    rdn_d   = 1'b1;
                    oen_d   = 1'b1;
                end
            end
            S_WR: begin
                // The word on dout is transferred at this edge no matter what
                // txen says; keep going only if the host still has room and a
                // further word is already buffered.
                if (!txen && (tx_cnt_q != 2'd0)) begin
                    tx_load = 1'b1;
                end else begin
                    state_d = S_TURN;
                    wrn_d   = 1'b1;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                oen_d   = 1'b1;
                rdn_d   = 1'b1;
                wrn_d   = 1'b1;
            end
        endcase
    end

    // Loading dout pops the transmit FIFO, so each word leaves exactly once.
    always_comb begin
        dout_d = dout_q;
        if (tx_load) begin
            dout_d = tx_mem_q[tx_rptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            oen_q     <= 1'b1;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            last_rd_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            oen_q     <= oen_d;
            rdn_q     <= rdn_d;
            wrn_q     <= wrn_d;
            last_rd_q <= last_rd_d;
            dout_q    <= dout_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO control and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q  <= 2'd0;
            rx_rptr_q  <= 2'd0;
            rx_cnt_q   <= 3'd0;
            rx_valid_q <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wptr_q <= rx_wptr_q + 2'd1;
            end
            if (rx_pop) begin
                rx_rptr_q <= rx_rptr_q + 2'd1;
            end
            rx_cnt_q   <= rx_cnt_d;
            rx_valid_q <= (rx_cnt_d != 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= din;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO control and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q  <= 1'b0;
            tx_rptr_q  <= 1'b0;
            tx_cnt_q   <= 2'd0;
            tx_ready_q <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wptr_q <= ~tx_wptr_q;
            end
            if (tx_load) begin
                tx_rptr_q <= ~tx_rptr_q;
            end
            tx_cnt_q   <= tx_cnt_d;
            tx_ready_q <= (tx_cnt_d != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= tx_data;
        end
    end

    assign dout     = dout_q;
    assign oen      = oen_q;
    assign rdn      = rdn_q;
    assign wrn      = wrn_q;
    assign rx_data  = rx_mem_q[rx_rptr_q];
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_ft245_sync_bridge.sv
module tb_ft245_sync_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rxfn = 1'b1;
    logic        txen = 1'b1;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        oen, rdn, wrn;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;

    always #5 clk = ~clk;

    ft245_sync_bridge #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxfn     (rxfn),
        .txen     (txen),
        .din      (din),
        .dout     (dout),
        .oen      (oen),
        .rdn      (rdn),
        .wrn      (wrn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    typedef struct {
        int          n;
        logic [31:0] base;
        int          mode;      // 0: rx_ready always 1, 1: ready one cycle in three
        int          span;      // capture span in cycles, -1: must exceed n-1
    } rd_vec_t;

    typedef struct {
        int          n;
        logic [31:0] base;
        int          lim;       // host raises txen once this many words are held
        int          exp_first; // words in the first burst (one-word margin)
    } wr_vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // host read side
    int          rx_n = 0, rx_idx = 0, rx_chunk = 0, rx_mode = 0;
    logic [31:0] rx_base = 32'd0;
    bit          rx_gap_en = 1'b0;
    bit          rd_cap_pending = 1'b0;
    int          first_cap = -1, last_cap = -1, cap_count = 0;
    int          oen_first = -1, rdn_first = -1;
    logic [31:0] rx_exp[$];

    // core transmit side
    int          tx_n = 0, tx_idx = 0;
    logic [31:0] tx_base = 32'd0;
    bit          tx_push_pending = 1'b0;

    // host write side
    logic [31:0] tx_exp[$];
    int          held = 0, since_gap = 0, limit = 1000000;
    bit          tx_gap_en = 1'b0;
    bit          wr_pending = 1'b0;
    logic [31:0] wr_word = 32'd0;
    bit          txen_follow = 1'b0;

    // burst ordering
    logic        prev_oen = 1'b1, prev_wrn = 1'b1;
    int          kinds[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic clear_models();
        rx_n = 0; rx_idx = 0; rx_chunk = 0; rx_mode = 0; rx_base = 32'd0;
        rx_gap_en = 1'b0; rd_cap_pending = 1'b0;
        first_cap = -1; last_cap = -1; cap_count = 0; oen_first = -1; rdn_first = -1;
        rx_exp.delete();
        tx_n = 0; tx_idx = 0; tx_base = 32'd0; tx_push_pending = 1'b0;
        tx_exp.delete();
        held = 0; since_gap = 0; limit = 1000000; tx_gap_en = 1'b0;
        wr_pending = 1'b0; txen_follow = 1'b0;
        kinds.delete();
    endtask

    // One bus cycle: everything is observed and driven at the falling edge.
    task automatic cycle();
        logic nt;
        logic viol;
        @(negedge clk);
        cyc++;

        viol = (~oen & ~wrn) | (~prev_oen & ~wrn) | (~prev_wrn & ~oen);
        check("strobe_exclusive", {31'd0, viol}, 32'd0);
        if (prev_oen && !oen) kinds.push_back(0);
        if (prev_wrn && !wrn) kinds.push_back(1);
        if (!oen && oen_first < 0) oen_first = cyc;
        if (!rdn && rdn_first < 0) rdn_first = cyc;
        prev_oen = oen;
        prev_wrn = wrn;

        if (txen_follow) begin
            check("wrn_after_txen_high", {31'd0, wrn}, 32'd1);
            txen_follow = 1'b0;
        end

        // host read model
        if (rd_cap_pending) begin
            rx_idx++;
            rx_chunk++;
            cap_count++;
        end
        if (rx_idx >= rx_n) begin
            rxfn = 1'b1;
        end else if (rx_gap_en && rx_chunk >= 3) begin
            rxfn = 1'b1;
            rx_chunk = 0;
        end else begin
            rxfn = 1'b0;
        end
        din = rx_base + 32'(rx_idx);
        rd_cap_pending = !rdn && !rxfn;
        if (rd_cap_pending) begin
            if (first_cap < 0) first_cap = cyc;
            last_cap = cyc;
        end

        // receive sink
        rx_ready = (rx_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_extra: got %h want no word", rx_data);
            end else begin
                check("rx_data", rx_data, rx_exp.pop_front());
            end
        end

        // core transmit source
        if (tx_push_pending) tx_idx++;
        tx_valid = (tx_idx < tx_n);
        tx_data  = tx_base + 32'(tx_idx);
        tx_push_pending = tx_valid && tx_ready;

        // host write model
        if (wr_pending) begin
            if (tx_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_extra: got %h want no word", wr_word);
            end else begin
                check("tx_word", wr_word, tx_exp.pop_front());
            end
            held++;
            since_gap++;
        end
        nt = (held >= limit);
        if (tx_gap_en && since_gap >= 3) begin
            nt = 1'b1;
            since_gap = 0;
        end
        if (nt && !txen && !wrn) txen_follow = 1'b1;
        txen = nt;
        wr_pending = !wrn;
        wr_word = dout;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_oen", {31'd0, oen}, 32'd1);
        check("rst_rdn", {31'd0, rdn}, 32'd1);
        check("rst_wrn", {31'd0, wrn}, 32'd1);
        check("rst_dout", dout, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        clear_models();
        rxfn = 1'b1; txen = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        prev_oen = 1'b1; prev_wrn = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_read(input rd_vec_t v);
        int start;
        clear_models();
        for (int i = 0; i < v.n; i++) rx_exp.push_back(v.base + 32'(i));
        rx_n = v.n; rx_base = v.base; rx_mode = v.mode;
        start = cyc + 1;
        for (int k = 0; k < 400 && !(rx_exp.size() == 0 && rx_idx >= rx_n && oen && rdn); k++) cycle();
        repeat (3) cycle();
        check("rd_left", 32'(rx_exp.size()), 32'd0);
        check("rd_captures", 32'(cap_count), 32'(v.n));
        check("rd_oen_time", 32'(oen_first), 32'(start + 1));
        check("rd_rdn_time", 32'(rdn_first), 32'(start + 2));
        check("rd_first_cap", 32'(first_cap), 32'(start + 2));
        if (v.span >= 0)
            check("rd_span", 32'(last_cap - first_cap), 32'(v.span));
        else
            check("rd_paused", {31'd0, (last_cap - first_cap) > (v.n - 1)}, 32'd1);
        check("rd_end_oen", {31'd0, oen}, 32'd1);
        check("rd_end_rdn", {31'd0, rdn}, 32'd1);
        check("rd_end_valid", {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic run_write(input wr_vec_t v);
        clear_models();
        for (int i = 0; i < v.n; i++) tx_exp.push_back(v.base + 32'(i));
        tx_n = v.n; tx_base = v.base; limit = v.lim;
        for (int k = 0; k < 400 && !(held >= v.lim && txen && wrn && !wr_pending); k++) cycle();
        check("wr_first_burst", 32'(held), 32'(v.exp_first));
        limit = 1000000;
        for (int k = 0; k < 400 && !(tx_exp.size() == 0 && wrn && !wr_pending); k++) cycle();
        repeat (3) cycle();
        check("wr_total", 32'(held), 32'(v.n));
        check("wr_left", 32'(tx_exp.size()), 32'd0);
        check("wr_end_wrn", {31'd0, wrn}, 32'd1);
    endtask

    rd_vec_t rd_tab[3];
    wr_vec_t wr_tab[3];

    initial begin
        rd_tab[0] = '{n: 1,  base: 32'hA5A5_0001, mode: 0, span: 0};
        rd_tab[1] = '{n: 16, base: 32'h1000_0000, mode: 0, span: 15};
        rd_tab[2] = '{n: 16, base: 32'h2000_0000, mode: 1, span: -1};
        wr_tab[0] = '{n: 8,  base: 32'hC0DE_0000, lim: 7, exp_first: 8};
        wr_tab[1] = '{n: 12, base: 32'h5500_0000, lim: 4, exp_first: 5};
        wr_tab[2] = '{n: 3,  base: 32'h7700_0000, lim: 1, exp_first: 2};

        do_reset();
        cycle();
        check("tx_ready_after_reset", {31'd0, tx_ready}, 32'd1);

        for (int i = 0; i < 3; i++) run_read(rd_tab[i]);
        for (int i = 0; i < 3; i++) run_write(wr_tab[i]);

        // asynchronous reset in the middle of a read burst
        clear_models();
        for (int i = 0; i < 16; i++) rx_exp.push_back(32'h3000_0000 + 32'(i));
        rx_n = 16; rx_base = 32'h3000_0000;
        repeat (6) cycle();
        check("mid_burst_oen", {31'd0, oen}, 32'd0);
        do_reset();
        cycle();
        cycle();
        check("flushed_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("post_rst_oen", {31'd0, oen}, 32'd1);
        check("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);

        // read and write pending together: bursts must alternate
        clear_models();
        for (int i = 0; i < 12; i++) rx_exp.push_back(32'h4000_0000 + 32'(i));
        for (int i = 0; i < 12; i++) tx_exp.push_back(32'h8000_0000 + 32'(i));
        rx_n = 12; rx_base = 32'h4000_0000; rx_gap_en = 1'b1;
        tx_n = 12; tx_base = 32'h8000_0000; tx_gap_en = 1'b1;
        for (int k = 0; k < 800 && !(rx_exp.size() == 0 && tx_exp.size() == 0 &&
                                   rx_idx >= rx_n && oen && rdn && wrn && !wr_pending); k++) cycle();
        repeat (3) cycle();
        check("alt_bursts", {31'd0, kinds.size() >= 6}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < kinds.size()) check("alt_kind", 32'(kinds[i]), 32'(i % 2));
        end
        check("alt_rx_left", 32'(rx_exp.size()), 32'd0);
        check("alt_tx_left", 32'(tx_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
